// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
//   Shared constants and helpers for the multi-channel clock divider.
//   DIV_W_DEF : default divisor width
//   MIN_DIV   : smallest divisor a channel will ever run with
//   clamp_div : raises divisors below MIN_DIV (0 and 1) to MIN_DIV
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int DIV_W_DEF = 16;
    localparam int MIN_DIV   = 2;

    // Operates on a 32-bit container so one function serves any DIV_W <= 32;
    // callers truncate the result back to their own width.
    function automatic logic [31:0] clamp_div(input logic [31:0] value);
        return (value < 32'(MIN_DIV)) ? 32'(MIN_DIV) : value;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// -----------------------------------------------------------------------------
// clk_div_channel
//   One divider channel: period counter, shadow divisor with pending flag,
//   apply logic and registered clock / strobe outputs.
//
//   clk_in     in  system clock
//   aresetn    in  asynchronous active-low reset
//   en         in  run enable; low holds the counter at 0 and outputs low
//   restart    in  realign counter to 0 and apply any pending divisor
//   wr         in  load wr_div into the shadow (only asserted while !pend)
//   wr_div     in  new divisor, already clamped to >= 2
//   clk_out    out divided clock, high for floor(D/2) of every D cycles
//   strobe_out out one-cycle pulse on the last count of each period
//   pend       out shadow divisor waiting for a period boundary
// -----------------------------------------------------------------------------
module clk_div_channel #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk_in,
    input  logic             aresetn,
    input  logic             en,
    input  logic             restart,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    output logic             clk_out,
    output logic             strobe_out,
    output logic             pend
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_pend;

    logic             wrap;
    logic             apply_now;
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] cnt_next;
    logic             clk_next;
    logic             strobe_next;

    // A pending divisor goes live at the natural wrap, or immediately when
    // the channel is idle or being realigned, since no period is in flight.
    assign wrap      = (cnt == div_act - DIV_W'(1));
    assign apply_now = pend && (restart || !en || wrap);
    assign div_eff   = apply_now ? div_pend : div_act;

    always_comb begin
        cnt_next    = '0;
        clk_next    = 1'b0;
        strobe_next = 1'b0;
        if (restart) begin
            // Count 0 is always in the high phase because every divisor >= 2.
            clk_next = en;
        end else if (en) begin
            cnt_next    = wrap ? '0 : cnt + DIV_W'(1);
            // Outputs are decoded from the count being entered, using the
            // divisor that count belongs to, so the flops line up with cnt.
            clk_next    = (cnt_next < (div_eff >> 1));
            strobe_next = (cnt_next == div_eff - DIV_W'(1));
        end
    end

    always_ff @(posedge clk_in or negedge aresetn) begin
        if (!aresetn) begin
            cnt        <= '0;
            div_act    <= DIV_W'(DEFAULT_DIV);
            div_pend   <= DIV_W'(DEFAULT_DIV);
            pend       <= 1'b0;
            clk_out    <= 1'b0;
            strobe_out <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            clk_out    <= clk_next;
            strobe_out <= strobe_next;
            if (apply_now) begin
                div_act <= div_pend;
            end
            // wr only arrives while pend is clear, so it never races an apply.
            if (wr) begin
                div_pend <= wr_div;
                pend     <= 1'b1;
            end else if (apply_now) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_divider_mc.sv
// -----------------------------------------------------------------------------
// clk_divider_mc
//   N_CH independent clock dividers off clk_in with glitch-free registered
//   outputs. Divisors are written through a valid/ready port and take effect
//   only at a period boundary.
//
//   clk_in       in  system clock (only clock)
//   aresetn      in  asynchronous active-low reset
//   en           in  [N_CH]  per-channel run enable
//   sync_restart in  one-cycle pulse realigning every channel to count 0
//   div_value    in  [DIV_W] new divisor (0 and 1 are treated as 2)
//   div_ch       in  [CH_W]  target channel; out-of-range writes are dropped
//   div_valid    in  divisor write request
//   div_ready    out write accepted when div_valid && div_ready
//   clk_out      out [N_CH]  divided clocks
//   strobe_out   out [N_CH]  last-count-of-period pulses
//
//   DIV_W must not exceed 32.
// -----------------------------------------------------------------------------
module clk_divider_mc
    import clk_div_pkg::*;
#(
    parameter  int N_CH        = 4,
    parameter  int DIV_W       = DIV_W_DEF,
    parameter  int DEFAULT_DIV = 4,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_in,
    input  logic             aresetn,
    input  logic [N_CH-1:0]  en,
    input  logic             sync_restart,
    input  logic [DIV_W-1:0] div_value,
    input  logic [CH_W-1:0]  div_ch,
    input  logic             div_valid,
    output logic             div_ready,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  strobe_out
);

    logic [N_CH-1:0]  pend;
    logic [N_CH-1:0]  wr;
    logic [DIV_W-1:0] div_clamped;

    assign div_clamped = DIV_W'(clamp_div(32'(div_value)));

    // A channel with a divisor still waiting for its boundary back-pressures.
    // Addresses with no channel behind them stay ready so a stray write
    // completes and is silently dropped instead of hanging the master.
    always_comb begin
        div_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (div_ch == CH_W'(i)) begin
                div_ready = !pend[i];
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign wr[g] = div_valid && div_ready && (div_ch == CH_W'(g));

        clk_div_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_in     (clk_in),
            .aresetn    (aresetn),
            .en         (en[g]),
            .restart    (sync_restart),
            .wr         (wr[g]),
            .wr_div     (div_clamped),
            .clk_out    (clk_out[g]),
            .strobe_out (strobe_out[g]),
            .pend       (pend[g])
        );
    end

endmodule

// File: tb/tb_clk_divider_mc.sv
// -----------------------------------------------------------------------------
// tb_clk_divider_mc
//   Directed bench for clk_divider_mc (4 channels, 16-bit divisors).
//   Stimulus pushes hand-timed expectations (cycle, signal, value) into a
//   scoreboard; a monitor pops and compares at every falling edge.
//   Cycle numbers are relative to the first edge after reset release.
// -----------------------------------------------------------------------------
module tb_clk_divider_mc;

    logic        clk_in = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  en = '0;
    logic        sync_restart = 1'b0;
    logic [15:0] div_value = '0;
    logic [1:0]  div_ch = '0;
    logic        div_valid = 1'b0;
    logic        div_ready;
    logic [3:0]  clk_out;
    logic [3:0]  strobe_out;

    always #5 clk_in = ~clk_in;

    clk_divider_mc #(
        .N_CH        (4),
        .DIV_W       (16),
        .DEFAULT_DIV (4)
    ) dut (
        .clk_in       (clk_in),
        .aresetn      (aresetn),
        .en           (en),
        .sync_restart (sync_restart),
        .div_value    (div_value),
        .div_ch       (div_ch),
        .div_valid    (div_valid),
        .div_ready    (div_ready),
        .clk_out      (clk_out),
        .strobe_out   (strobe_out)
    );

    // kind: 0 = clk_out[ch], 1 = strobe_out[ch], 2 = div_ready
    typedef struct {
        int   cyc;
        int   kind;
        int   ch;
        logic val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   t0    = 0;
    logic done  = 1'b0;
    logic mon_act;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic string kname(input int kind);
        case (kind)
            0:       return "clk_out";
            1:       return "strobe_out";
            default: return "div_ready";
        endcase
    endfunction

    task automatic push(input int rel, input int kind, input int ch, input logic val);
        exp_t e;
        e.cyc  = t0 + rel;
        e.kind = kind;
        e.ch   = ch;
        e.val  = val;
        sb.push_back(e);
    endtask

    // Expected waveform of one channel running divisor d, at phase ph0 on rel_from.
    task automatic exp_run(input int ch, input int rel_from, input int rel_to,
                           input int d, input int ph0);
        for (int r = rel_from; r <= rel_to; r++) begin
            int ph;
            ph = (ph0 + r - rel_from) % d;
            push(r, 0, ch, ph < d / 2);
            push(r, 1, ch, ph == d - 1);
        end
    endtask

    task automatic exp_zero(input int ch, input int rel_from, input int rel_to);
        for (int r = rel_from; r <= rel_to; r++) begin
            push(r, 0, ch, 1'b0);
            push(r, 1, ch, 1'b0);
        end
    endtask

    task automatic exp_rdy(input int rel, input logic val);
        push(rel, 2, 0, val);
    endtask

    task automatic to_rel(input int r);
        while (cyc < t0 + r) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Monitor: compare every expectation due on this cycle; at the end any
    // expectation never reached is a failure.
    initial begin
        forever begin
            @(negedge clk_in);
            if (done) begin
                while (sb.size() > 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unchecked %s ch%0d rel %0d: got no sample, expected %b",
                             kname(sb[0].kind), sb[0].ch, sb[0].cyc - t0, sb[0].val);
                    sb.delete(0);
                end
            end else begin
                for (int i = sb.size() - 1; i >= 0; i--) begin
                    if (sb[i].cyc == cyc) begin
                        case (sb[i].kind)
                            0:       mon_act = clk_out[sb[i].ch];
                            1:       mon_act = strobe_out[sb[i].ch];
                            default: mon_act = div_ready;
                        endcase
                        n_cmp++;
                        if (mon_act !== sb[i].val) begin
                            n_bad++;
                            $display("FAIL %s ch%0d rel %0d: got %b expected %b",
                                     kname(sb[i].kind), sb[i].ch, sb[i].cyc - t0,
                                     mon_act, sb[i].val);
                        end
                        sb.delete(i);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk_in);
        #1 aresetn = 1'b1;
        @(posedge clk_in);
        #1 t0 = cyc;

        // ---- stage 1: reset state, default /4, divisor writes ------------
        for (int c = 0; c < 4; c++) begin
            push(0, 0, c, 1'b0);
            push(0, 1, c, 1'b0);
        end
        exp_rdy(0, 1'b1);
        exp_rdy(5, 1'b1);
        // ch0: /4, then 10 (second write 3 stalls), then 3, then 5
        exp_run(0, 1, 23, 4, 1);
        exp_run(0, 24, 33, 10, 0);
        exp_run(0, 34, 39, 3, 0);
        exp_run(0, 40, 45, 5, 0);
        // ch1: /4 until the wrap after the write, then 7 (high 3 / low 4)
        exp_run(1, 1, 15, 4, 1);
        exp_run(1, 16, 45, 7, 0);
        // ch2: divisor 0 is clamped to 2
        exp_run(2, 1, 19, 4, 1);
        exp_run(2, 20, 45, 2, 0);
        // ch3: /4 then 8
        exp_run(3, 1, 39, 4, 1);
        exp_run(3, 40, 45, 8, 0);
        exp_rdy(13, 1'b1); exp_rdy(14, 1'b0); exp_rdy(15, 1'b0); exp_rdy(16, 1'b1);
        exp_rdy(17, 1'b1); exp_rdy(18, 1'b0); exp_rdy(19, 1'b0); exp_rdy(20, 1'b1);
        exp_rdy(21, 1'b1); exp_rdy(22, 1'b0); exp_rdy(23, 1'b0); exp_rdy(24, 1'b1);
        for (int r = 25; r <= 33; r++) exp_rdy(r, 1'b0);
        exp_rdy(34, 1'b1); exp_rdy(35, 1'b1); exp_rdy(36, 1'b1); exp_rdy(37, 1'b1);
        exp_rdy(38, 1'b0); exp_rdy(39, 1'b0); exp_rdy(40, 1'b1);

        en = 4'hF;
        to_rel(13); div_ch = 2'd1; div_value = 16'd7; div_valid = 1'b1;
        to_rel(14); div_valid = 1'b0;
        to_rel(17); div_ch = 2'd2; div_value = 16'd0; div_valid = 1'b1;
        to_rel(18); div_valid = 1'b0;
        to_rel(21); div_ch = 2'd0; div_value = 16'd10; div_valid = 1'b1;
        to_rel(22); div_value = 16'd3;
        to_rel(25); div_valid = 1'b0;
        to_rel(36); div_ch = 2'd0; div_value = 16'd5; div_valid = 1'b1;
        to_rel(37); div_ch = 2'd3; div_value = 16'd8;
        to_rel(38); div_valid = 1'b0;

        // ---- stage 2: sync_restart realigns all channels -----------------
        to_rel(45);
        exp_run(0, 46, 89, 5, 0);
        exp_run(1, 46, 89, 7, 0);
        exp_run(2, 46, 89, 2, 0);
        exp_run(3, 46, 89, 8, 0);
        exp_rdy(46, 1'b1);
        exp_rdy(88, 1'b1);
        exp_rdy(89, 1'b0);
        sync_restart = 1'b1;
        to_rel(46); sync_restart = 1'b0;
        to_rel(88); div_ch = 2'd3; div_value = 16'd6; div_valid = 1'b1;

        // ---- stage 3: async reset mid-period with ch3 pending ------------
        to_rel(89);
        div_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            exp_zero(c, 90, 92);
            exp_run(c, 93, 104, 4, 1);
        end
        exp_rdy(90, 1'b1); exp_rdy(91, 1'b1); exp_rdy(92, 1'b1); exp_rdy(93, 1'b1);
        to_rel(90); aresetn = 1'b0;
        to_rel(92); aresetn = 1'b1;

        // ---- stage 4: disable applies pending divisor, re-enable 0->1 ----
        to_rel(105);
        exp_run(0, 105, 120, 4, 1);
        exp_run(1, 105, 120, 4, 1);
        exp_run(3, 105, 120, 4, 1);
        exp_run(2, 105, 106, 4, 1);
        exp_zero(2, 107, 108);
        exp_run(2, 109, 120, 6, 1);
        exp_rdy(105, 1'b1); exp_rdy(106, 1'b0); exp_rdy(107, 1'b1); exp_rdy(108, 1'b1);
        div_ch = 2'd2; div_value = 16'd6; div_valid = 1'b1;
        to_rel(106); div_valid = 1'b0; en = 4'b1011;
        to_rel(108); en = 4'hF;

        to_rel(122);
        done = 1'b1;
        repeat (2) @(negedge clk_in);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_divider_mc.md
# clk_divider_mc

Parametrised multi-channel clock divider: N_CH independent channels, each dividing `clk_in` by a runtime-programmable integer and producing a registered, glitch-free divided clock and a one-cycle period strobe. Divisor updates use a valid/ready handshake and take effect only at a period boundary, so no truncated or stretched periods occur. It sits next to the DAQ timing logic, feeding sampling, readout and trigger-window strobes from the single 100 MHz fabric clock.

## Interface
Parameters:
- `N_CH`, 4, number of divider channels (1..16)
- `DIV_W`, 16, divisor width in bits
- `DEFAULT_DIV`, 4, divisor loaded into every channel at reset (≥2)

Ports:
- `clk_in`  in  1  system clock; the only clock
- `aresetn`  in  1  asynchronous active-low reset
- `en`  in  N_CH  per-channel run enable
- `sync_restart`  in  1  one-cycle pulse; realigns all channels to count 0
- `div_value`  in  DIV_W  new divisor
- `div_ch`  in  $clog2(N_CH) (min 1)  target channel
- `div_valid`  in  1  divisor write request
- `div_ready`  out  1  write accepted when `div_valid && div_ready`
- `clk_out`  out  N_CH  divided clocks
- `strobe_out`  out  N_CH  one-cycle pulse on last count of each period

## Operation
- Per channel: counter `cnt` (DIV_W bits), active divisor `div_act`, shadow `div_pend`, flag `pend`.
- Enabled channel: `cnt_next = (cnt == div_act-1) ? 0 : cnt+1`.
- `clk_out[i] <= (cnt_next < div_act>>1)`; `strobe_out[i] <= (cnt_next == div_act-1)`. Odd divisors: high floor(D/2), low ceil(D/2).
- Divisor values 0 and 1 are clamped to 2 on acceptance.
- Handshake: `div_ready = !pend[div_ch]` (combinational). On transfer: `div_pend <= clamp(div_value)`, `pend <= 1`. Out-of-range `div_ch` (≥N_CH): `div_ready=1`, write discarded.
- Apply: when `cnt == div_act-1` on an enabled edge, `div_act <= div_pend`, `pend <= 0`; the new period starts at count 0 with the new divisor.
- `en[i]=0`: `cnt` held at 0, `clk_out[i]=0`, `strobe_out[i]=0`; a pending divisor is applied on the next edge. Re-enable: first edge moves `cnt` 0→1.
- `sync_restart`: all channels `cnt <= 0`, pending divisors applied immediately, `clk_out <= 1` for enabled channels, `strobe_out <= 0`. Overrides wrap and the enable rising edge.
- Simultaneous write and apply on the same channel: apply uses the old `div_pend`; `div_ready` was 0, so no conflict exists.

## Timing
- Reset values: `cnt=0`, `div_act=DEFAULT_DIV`, `pend=0`, `clk_out=0`, `strobe_out=0`, `div_ready=1`.
- Outputs are registered; they change one edge after the corresponding count update. No combinational path from inputs to `clk_out`/`strobe_out`.
- Divisor latency: the write is accepted at edge k. The new period begins at the first wrap after k, or at edge k+1 if the channel is disabled or `sync_restart` is asserted at k+1.
- Reset asserted mid-period: all state clears asynchronously. Counting resumes on the first edge after release.
- Period D cycles; exactly one `strobe_out` per period.

## Structure
- Package `clk_div_pkg`: `DIV_W_DEF`, `MIN_DIV=2`, function `clamp_div`.
- Sub-module `clk_div_channel`: counter, shadow and apply logic, and output flops for one channel, instantiated N_CH times in a generate loop. The top module holds the handshake decode and `sync_restart` fan-out.

## Test plan
- Reset then `en=4'b1111`, default 4 → every `clk_out` toggles every 2 cycles; `strobe_out` pulses every 4th cycle, coincident with the last low cycle.
- Write ch1 `div_value=7` mid-period → the current 4-cycle period completes, then high 3/low 4; `div_ready` is low for ch1 until the apply edge.
- Write ch2 `div_value=0` → behaves as divide-by-2 (1 high, 1 low, strobe every 2 cycles).
- Write ch0 = 10, then a second write to ch0 before wrap → `div_ready=0`; the second write stalls until the apply edge, then is accepted.
- Channels 0 and 3 at divisors 5 and 8 drifting, pulse `sync_restart` → both `clk_out` rise on the next edge and their rising edges coincide every 40 cycles.
- Deassert `aresetn` mid-period with ch3 pending → outputs 0, `div_act=4`, pending discarded; operation resumes cleanly after release.
